dot_product_4x4: RTL and testbench
==================================

# dot_product_4x4

Sequential dot-product engine built around the combinational 4x4 array multiplier, Mult_4x4. Accepts a stream of unsigned 4-bit operand pairs over a valid/ready handshake and registers each pair into the multiplier. Accumulates the 8-bit products over LEN pairs and presents the saturated sum on a valid/ready output port. Sits directly upstream of the multiplier: it feeds the multiplier's operands and consumes its product.

## Interface
- LEN, 4: operand pairs per dot product; legal range 1..16.
- ACC_W, 10: accumulator and result width; must be at least 8.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_x  input  4  operand X (unsigned).
- in_y  input  4  operand Y (unsigned).
- in_ready  output  1  block accepts a pair this cycle.
- out_valid  output  1  result valid.
- out_data  output  ACC_W  dot-product result.
- out_ovf  output  1  result saturated.
- out_ready  input  1  consumer accepts the result.

## Operation
- A pair transfers on a rising edge with in_valid && in_ready. An output transfers on a rising edge with out_valid && out_ready.
- Stage 1 register: x_r, y_r, v1 and last1. Captures on every input transfer. v1 clears on any cycle with no transfer. x_r and y_r drive one Mult_4x4 instance, whose product is P[7:0].
- Stage 2: unsigned accumulator acc[ACC_W-1:0] with sticky flag ovf.
  - When v1=1: next = acc + P, computed at ACC_W+1 bits.
  - If next exceeds 2^ACC_W-1, acc saturates to all ones and ovf sets.
  - Once saturated, acc stays at all ones for the remaining pairs.
- Input counter cnt, 0..LEN. Increments on each input transfer. last1 is set for the transfer that brings cnt to LEN.
- FSM states:
  - RUN: in_ready=1. An input transfer with cnt==LEN-1 moves the FSM to WAIT.
  - WAIT: in_ready=0, one cycle. The last product accumulates. out_data is loaded with the saturated acc+P, out_ovf with the final ovf, and out_valid is set. The FSM moves to DONE.
  - DONE: in_ready=0. out_valid, out_data and out_ovf hold stable until an output transfer. On that transfer: out_valid=0, acc=0, ovf=0, cnt=0, and the FSM moves to RUN.
- in_valid gaps during RUN are legal. Pair count is what matters, not cycle count.
- in_x and in_y are ignored when in_valid=0 or in_ready=0.
- LEN=1: RUN moves to WAIT on the first transfer.

## Timing
- Reset state, applied on any edge with rst=1, including mid-run: FSM=RUN, cnt=0, v1=0, acc=0, ovf=0, in_ready=1, out_valid=0, out_data=0, out_ovf=0. Partial sums are discarded. A result that was pending in DONE is dropped.
- in_ready is a registered function of FSM state only. It does not depend combinationally on in_valid or out_ready.
- Throughput: one pair per cycle while in RUN.
- Latency:
  - The last pair is accepted at edge E.
  - It is in stage 1 after E.
  - out_valid is high after edge E+1.
  - That gives 2 cycles from the last accepted pair to the result.
- Minimum dot-product period: LEN+1 cycles, plus the cycles spent waiting in DONE.
- Result transfer at edge T: in_ready=1 after T, so the first pair of the next dot product can transfer at T+1.
- out_ready=1 while out_valid=0 has no effect.
- out_data and out_ovf change only on the WAIT-to-DONE edge or on reset.

## Test plan
- Reset, then LEN=4 pairs (2,4),(15,3),(1,1),(0,9) on consecutive cycles with out_ready=1 -> out_valid high 2 cycles after the last pair, out_data=54, out_ovf=0, in_ready=0 from the edge after the 4th transfer until after the output transfer.
- Four pairs (15,15), ACC_W=10 -> out_data=900, out_ovf=0. Repeat with ACC_W=9 -> out_data=511, out_ovf=1.
- Pairs (3,5),(7,7),(1,2),(4,4) with in_valid low for 2 cycles between each pair -> out_data=82, with the same 2-cycle latency measured from the last transfer.
- Hold out_ready=0 for 5 cycles after out_valid rises -> out_data and out_ovf stable, in_ready=0, new in_valid ignored. On release: one output transfer, in_ready=1 next cycle, and the next dot product (4x(1,1)) gives 4 with ovf=0.
- Assert rst for 1 cycle after 2 of 4 pairs are accepted -> all outputs at reset values the next cycle. A fresh 4 pairs (1,1),(2,2),(3,3),(4,4) gives 30, with no contribution from the aborted pairs.
- Reset while in DONE with out_ready=0 -> out_valid=0 the next cycle, and the pending result is never transferred.

Source files
------------

// File: rtl/dot_product_4x4.sv
// Streaming 4-bit dot-product engine: registers operand pairs into a 4x4 array
// multiplier and accumulates LEN products into a saturating result.

module Mult_4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  logic [7:0] w_row [0:4];

  assign w_row[0] = '0;

  // One shifted partial-product row per multiplier bit, summed in a chain.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      logic [7:0] w_pp;
      assign w_pp          = {4'b0000, i_a & {4{i_b[gi]}}} << gi;
      assign w_row[gi + 1] = w_row[gi] + w_pp;
    end
  endgenerate

  assign o_p = w_row[4];
endmodule

module dot_product_4x4 #(
  parameter int LEN   = 4,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_x,
  input  logic [3:0]       in_y,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             out_ready
);
  localparam int CNT_W = $clog2(LEN + 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_x;
  logic [3:0]       r_y;
  logic             r_v1;
  logic             r_last1;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_data;
  logic             r_out_ovf;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_cnt_last;
  logic [7:0]       w_prod;
  logic [ACC_W:0]   w_sum;
  logic             w_sum_ovf;
  logic [ACC_W-1:0] w_acc_sat;

  assign in_ready   = (r_state == S_RUN);
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_ovf    = r_out_ovf;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_cnt_last = (r_cnt == CNT_W'(LEN - 1));

  Mult_4x4 u_mult (
    .i_a (r_x),
    .i_b (r_y),
    .o_p (w_prod)
  );

  // One extra bit catches the carry; saturated acc stays all ones because any
  // non-zero product overflows again and a zero product leaves it unchanged.
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W + 1 - 8){1'b0}}, w_prod};
  assign w_sum_ovf = w_sum[ACC_W];
  assign w_acc_sat = w_sum_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:   if (w_in_xfer && w_cnt_last) w_state_next = S_WAIT;
      S_WAIT:  w_state_next = S_DONE;
      S_DONE:  if (w_out_xfer) w_state_next = S_RUN;
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_v1        <= 1'b0;
      r_last1     <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_v1 <= w_in_xfer;
      if (w_in_xfer) begin
        r_x     <= in_x;
        r_y     <= in_y;
        r_last1 <= w_cnt_last;
        r_cnt   <= r_cnt + CNT_W'(1);
      end

      if (r_v1) begin
        r_acc <= w_acc_sat;
        r_ovf <= r_ovf | w_sum_ovf;
      end

      if (r_state == S_WAIT && r_v1 && r_last1) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_acc_sat;
        r_out_ovf   <= r_ovf | w_sum_ovf;
      end

      if (r_state == S_DONE && w_out_xfer) begin
        r_out_valid <= 1'b0;
        r_acc       <= '0;
        r_ovf       <= 1'b0;
        r_cnt       <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dot_product_4x4.sv
// Randomized and directed bench for dot_product_4x4; two instances (ACC_W=10
// and ACC_W=9) share stimulus and are checked against an arithmetic model.

module tb_dot_product_4x4;
  localparam int LEN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_x;
  logic [3:0] in_y;
  logic       out_ready;

  logic       in_ready;
  logic       out_valid;
  logic [9:0] out_data;
  logic       out_ovf;
  logic       in_ready9;
  logic       out_valid9;
  logic [8:0] out_data9;
  logic       out_ovf9;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_sum  = 0;

  always #5 clk = ~clk;

  dot_product_4x4 #(.LEN(LEN), .ACC_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_ready (out_ready)
  );

  dot_product_4x4 #(.LEN(LEN), .ACC_W(9)) dut9 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_ready  (in_ready9),
    .out_valid (out_valid9),
    .out_data  (out_data9),
    .out_ovf   (out_ovf9),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int s, input int w);
    return (s > (1 << w) - 1) ? (1 << w) - 1 : s;
  endfunction

  function automatic int ovf(input int s, input int w);
    return (s > (1 << w) - 1) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string name);
    check({name, "_in_ready"},  in_ready,   1);
    check({name, "_out_valid"}, out_valid,  0);
    check({name, "_out_data"},  out_data,   0);
    check({name, "_out_ovf"},   out_ovf,    0);
    check({name, "_valid9"},    out_valid9, 0);
    check({name, "_data9"},     out_data9,  0);
  endtask

  // Idle for gap cycles, then offer one pair until it is accepted.
  task automatic send_pair(input int x, input int y, input int gap);
    int t;
    t = 0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_x     = 4'(x);
    in_y     = 4'(y);
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    check("in_ready_before_xfer", in_ready, 1);
    tick();
    exp_sum += x * y;
    in_valid = 1'b0;
    in_x     = 4'($urandom);
    in_y     = 4'($urandom);
  endtask

  // Called just after the edge that accepted the last pair.
  task automatic finish_dot(input int hold, input string name);
    int e10, o10, e9, o9;
    e10 = sat(exp_sum, 10);
    o10 = ovf(exp_sum, 10);
    e9  = sat(exp_sum, 9);
    o9  = ovf(exp_sum, 9);
    check({name, "_in_ready_after_last"}, in_ready, 0);
    check({name, "_valid_early"},         out_valid, 0);
    tick();
    check({name, "_valid"},    out_valid,  1);
    check({name, "_data"},     out_data,   e10);
    check({name, "_ovf"},      out_ovf,    o10);
    check({name, "_valid9"},   out_valid9, 1);
    check({name, "_data9"},    out_data9,  e9);
    check({name, "_ovf9"},     out_ovf9,   o9);
    check({name, "_in_ready"}, in_ready,   0);
    if (hold < 0) return;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_x      = 4'($urandom);
      in_y      = 4'($urandom);
      tick();
      check({name, "_hold_valid"},    out_valid, 1);
      check({name, "_hold_data"},     out_data,  e10);
      check({name, "_hold_ovf"},      out_ovf,   o10);
      check({name, "_hold_data9"},    out_data9, e9);
      check({name, "_hold_in_ready"}, in_ready,  0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check({name, "_xfer_valid"},    out_valid,  0);
    check({name, "_xfer_valid9"},   out_valid9, 0);
    check({name, "_xfer_in_ready"}, in_ready,   1);
    exp_sum = 0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check_reset("reset");

    out_ready = 1'b1;
    send_pair(2, 4, 0);
    send_pair(15, 3, 0);
    send_pair(1, 1, 0);
    send_pair(0, 9, 0);
    finish_dot(0, "basic");

    out_ready = 1'b0;
    for (int i = 0; i < LEN; i++) send_pair(15, 15, 0);
    finish_dot(0, "maxval");

    send_pair(3, 5, 0);
    send_pair(7, 7, 2);
    send_pair(1, 2, 2);
    send_pair(4, 4, 2);
    finish_dot(0, "gaps");

    for (int i = 0; i < LEN; i++) send_pair(2, 3, 0);
    finish_dot(5, "backpressure");
    for (int i = 0; i < LEN; i++) send_pair(1, 1, 0);
    finish_dot(0, "after_bp");

    send_pair(5, 5, 0);
    send_pair(6, 6, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_sum = 0;
    check_reset("midrun_rst");
    send_pair(1, 1, 0);
    send_pair(2, 2, 0);
    send_pair(3, 3, 0);
    send_pair(4, 4, 0);
    finish_dot(0, "after_rst");

    out_ready = 1'b0;
    for (int i = 0; i < LEN; i++) send_pair(9, 9, 0);
    finish_dot(-1, "done_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_sum = 0;
    check_reset("done_rst_reset");
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dropped_valid",    out_valid, 0);
      check("dropped_in_ready", in_ready,  1);
    end

    for (int n = 0; n < 25; n++) begin
      out_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < LEN; i++)
        send_pair(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 2)));
      finish_dot(int'($urandom_range(0, 3)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
